uart_ctrl_seq: RTL

Bus-master sequencer that sits in front of one AHBUart peripheral's bus_protocol_if slave port. It programs the UART's configuration registers after reset or on request, then drains a small byte FIFO into the UART transmit register, polling status so that no byte is written while the transmitter is busy. Datapath blocks push bytes through a valid/ready port and never touch UART registers directly.

---
 rtl/uart_seq_pkg.sv | 50 +++++
 rtl/uart_seq_fifo.sv | 45 ++++
 rtl/uart_ctrl_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and default register map for the AHBUart sequencer.
// The CFG_VERIFY state exists only with UART_SEQ_CFG_VERIFY_EN defined.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_RATE,
        CFG_CTRL,
`ifdef UART_SEQ_CFG_VERIFY_EN
        CFG_VERIFY,
`endif
        POLL,
        WR_TX
    } state_t;

    localparam logic [31:0] DEF_RATE_ADDR   = 32'd24;
    localparam logic [31:0] DEF_CTRL_ADDR   = 32'd20;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'd0;
    localparam logic [31:0] DEF_TXDATA_ADDR = 32'd8;
    localparam int          DEF_TX_BUSY_BIT = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ren;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '0;

    function automatic bus_req_t bus_wr(input logic [31:0] addr,
                                        input logic [31:0] data);
        bus_req_t r;
        r.addr  = addr;
        r.wdata = data;
        r.wen   = 1'b1;
        r.ren   = 1'b0;
        return r;
    endfunction

    function automatic bus_req_t bus_rd(input logic [31:0] addr);
        bus_req_t r;
        r.addr  = addr;
        r.wdata = 32'h0;
        r.wen   = 1'b0;
        r.ren   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/uart_seq_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit.
// A push while full is honoured only when a pop happens in the same cycle.
module uart_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl_seq.sv
// Bus master that configures an AHBUart, then drains a TX byte FIFO.
// Optional rate readback after configuration: UART_SEQ_CFG_VERIFY_EN.
module uart_ctrl_seq
    import uart_seq_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] RATE_ADDR   = DEF_RATE_ADDR,
    parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [31:0] TXDATA_ADDR = DEF_TXDATA_ADDR,
    parameter int          TX_BUSY_BIT = DEF_TX_BUSY_BIT
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        cfg_start,
    input  logic [31:0] cfg_rate,
    input  logic [31:0] cfg_ctrl,
    output logic        cfg_done,
    output logic        cfg_error,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        busy,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic [31:0] bus_rdata,
    input  logic        bus_request_stall,
    input  logic        bus_error
);
    localparam logic [31:0] BUSY_MASK = 32'h1 << TX_BUSY_BIT;

    state_t      state, state_n;
    bus_req_t    req_q, req_n;
    logic [31:0] rate_q, rate_n;
    logic [31:0] ctrl_q, ctrl_n;
    logic        done_n, error_n;
    logic        full, empty, push, pop, pending;
    logic        bus_idle, xfer_done, tx_busy;
    logic [7:0]  head;

    uart_seq_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (8)
    ) u_fifo (
        .clk   (clk),
        .nReset(nReset),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign tx_ready   = !full;
    assign push       = tx_valid && tx_ready;
    assign pending    = !empty || push;
    assign busy       = (state != IDLE) || !empty;
    assign bus_idle   = !(req_q.wen || req_q.ren);
    assign xfer_done  = !bus_idle && !bus_request_stall;
    assign tx_busy    = |(bus_rdata & BUSY_MASK);

    assign bus_addr   = req_q.addr;
    assign bus_wdata  = req_q.wdata;
    assign bus_wen    = req_q.wen;
    assign bus_ren    = req_q.ren;
    assign bus_strobe = 4'hF;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            req_q     <= BUS_IDLE;
            rate_q    <= '0;
            ctrl_q    <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_n;
            req_q     <= req_n;
            rate_q    <= rate_n;
            ctrl_q    <= ctrl_n;
            cfg_done  <= done_n;
            cfg_error <= error_n;
        end
    end

    // Each transfer state issues when the bus is idle and waits for completion;
    // returning the request to idle on completion yields the gap cycle.
    always_comb begin
        state_n = state;
        req_n   = req_q;
        rate_n  = rate_q;
        ctrl_n  = ctrl_q;
        done_n  = cfg_done;
        error_n = cfg_error;
        pop     = 1'b0;
        if (xfer_done) req_n = BUS_IDLE;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    rate_n  = cfg_rate;
                    ctrl_n  = cfg_ctrl;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    state_n = CFG_RATE;
                    req_n   = bus_wr(RATE_ADDR, cfg_rate);
                end else if (cfg_done && pending) begin
                    state_n = POLL;
                    req_n   = bus_rd(STATUS_ADDR);
                end
            end
            CFG_RATE: begin
                if (bus_idle) begin
                    req_n = bus_wr(RATE_ADDR, rate_q);
                end else if (xfer_done) begin
                    if (bus_error) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end
`ifdef UART_SEQ_CFG_VERIFY_EN
                    else state_n = CFG_VERIFY;
`else
                    else state_n = CFG_CTRL;
`endif
                end
            end
`ifdef UART_SEQ_CFG_VERIFY_EN
            CFG_VERIFY: begin
                if (bus_idle) begin
                    req_n = bus_rd(RATE_ADDR);
                end else if (xfer_done) begin
                    if (bus_error || bus_rdata != rate_q) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = CFG_CTRL;
                    end
                end
            end
`endif
            CFG_CTRL: begin
                if (bus_idle) begin
                    req_n = bus_wr(CTRL_ADDR, ctrl_q);
                end else if (xfer_done) begin
                    if (bus_error) error_n = 1'b1;
                    else           done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            POLL: begin
                if (bus_idle) begin
                    req_n = bus_rd(STATUS_ADDR);
                end else if (xfer_done && !bus_error && !tx_busy) begin
                    state_n = WR_TX;
                end
            end
            WR_TX: begin
                if (bus_idle) begin
                    req_n = bus_wr(TXDATA_ADDR, {24'h0, head});
                end else if (xfer_done) begin
                    if (bus_error) begin
                        state_n = POLL;
                    end else begin
                        pop     = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = BUS_IDLE;
            end
        endcase
    end

endmodule
